// File: rtl/pwm_gen.sv
// Motor PWM generator: period-aligned ratio/direction updates with dead-time on reversal.
// Each applied request is acknowledged with a single-cycle pwm_done pulse.
module pwm_gen #(
  parameter int unsigned PRESCALE         = 64,
  parameter int unsigned DEADTIME_PERIODS = 2
) (
  input  logic       reset_n,
  input  logic       clock,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic       busy
);

  localparam int unsigned PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DC_W      = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
  localparam int unsigned TICK_W    = 8;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(254);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  state_t            state;
  logic [PS_W-1:0]   prescaler;
  logic [TICK_W-1:0] tick_cnt;
  logic [7:0]        active_ratio;
  logic [7:0]        pend_ratio;
  logic              pend_dir;
  logic              pend_valid;
  logic [DC_W-1:0]   dead_cnt;

  logic tick;
  logic boundary;
  logic same_dir;
  logic apply;
  logic enter_dead;
  logic dead_dec;

  // Period timebase and the decision taken at each boundary (or immediately when disabled).
  always_comb begin
    tick       = (prescaler == PS_W'(PRESCALE - 1));
    boundary   = tick && (tick_cnt == TICK_LAST);
    same_dir   = (pend_dir == dir_out) || (pend_ratio == 8'd0);
    apply      = 1'b0;
    enter_dead = 1'b0;
    dead_dec   = 1'b0;
    if (pend_valid) begin
      if (!pwm_enable) begin
        // Holding off one cycle after a pulse keeps pwm_done from firing back to back.
        apply = !pwm_done;
      end else if (boundary) begin
        if (state == RUN) begin
          if (same_dir) apply = 1'b1;
          else          enter_dead = 1'b1;
        end else if (dead_cnt == '0) begin
          apply = 1'b1;
        end else begin
          dead_dec = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      prescaler    <= '0;
      tick_cnt     <= '0;
      active_ratio <= 8'd0;
      pend_ratio   <= 8'd0;
      pend_dir     <= 1'b0;
      pend_valid   <= 1'b0;
      dead_cnt     <= '0;
      pwm_done     <= 1'b0;
      pwm_out      <= 1'b0;
      dir_out      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pwm_done <= 1'b0;

      if (pwm_enable) begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
        if (tick) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
        pwm_out <= (state == RUN) && (tick_cnt < active_ratio);
      end else begin
        prescaler <= '0;
        tick_cnt  <= '0;
        pwm_out   <= 1'b0;
        state     <= RUN;
      end

      if (apply) begin
        active_ratio <= pend_ratio;
        dir_out      <= pend_dir;
        pend_valid   <= 1'b0;
        pwm_done     <= 1'b1;
        state        <= RUN;
      end

      if (enter_dead) begin
        active_ratio <= 8'd0;
        dead_cnt     <= DC_W'(DEADTIME_PERIODS - 1);
        state        <= DEAD;
      end

      if (dead_dec) dead_cnt <= dead_cnt - DC_W'(1);

      // A strobe coinciding with an apply stays pending for the next boundary.
      if (pwm_update) begin
        pend_ratio <= pwm_ratio;
        pend_dir   <= pwm_direction;
        pend_valid <= 1'b1;
      end

      // DEAD is only ever occupied while a request is pending, so this covers both terms.
      busy <= pwm_update || (pend_valid && !apply);
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen with PRESCALE=1 so one PWM period is 255 clocks.
module tb_pwm_gen;

  localparam int unsigned PRESCALE         = 1;
  localparam int unsigned DEADTIME_PERIODS = 2;
  localparam int          PERIOD           = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pwm_enable = 1'b0;
  logic       pwm_update = 1'b0;
  logic [7:0] pwm_ratio = 8'd0;
  logic       pwm_direction = 1'b0;
  logic       pwm_done;
  logic       pwm_out;
  logic       dir_out;
  logic       busy;

  pwm_gen #(.PRESCALE(PRESCALE), .DEADTIME_PERIODS(DEADTIME_PERIODS)) dut (
    .reset_n      (reset_n),
    .clock        (clock),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_done     (pwm_done),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] ratio;
    logic       dir;
    int         periods;
    int         max_lat;
    int         min_low;
  } vec_t;

  typedef struct {
    logic [7:0] ratio;
    logic       dir;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_pending;
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive a one-cycle strobe from a negedge; the scoreboard keeps only the latest pending request.
  task automatic send(input logic [7:0] r, input logic d);
    exp_t e;
    e.ratio = r;
    e.dir   = d;
    if (sb_pending && sb_q.size() > 0) sb_q[sb_q.size()-1] = e;
    else sb_q.push_back(e);
    sb_pending    = 1'b1;
    pwm_ratio     = r;
    pwm_direction = d;
    pwm_update    = 1'b1;
    @(negedge clock);
    pwm_update    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found, output int cycles,
                           output int low_run, output int busy_low);
    found = 1'b0; cycles = 0; low_run = 0; busy_low = 0;
    while (!found && cycles < budget) begin
      @(negedge clock);
      cycles++;
      low_run = pwm_out ? 0 : low_run + 1;
      if (pwm_done) found = 1'b1;
      else if (!busy) busy_low++;
    end
  endtask

  task automatic measure(input int periods, output int highs, output int first, output int dones);
    highs = 0; first = 0; dones = 0;
    for (int i = 0; i < PERIOD * periods; i++) begin
      @(negedge clock);
      if (i == 0) first = int'(pwm_out);
      highs += int'(pwm_out);
      dones += int'(pwm_done);
    end
  endtask

  task automatic pop_expected(input string name, output exp_t e);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard entry"}, 32'd0, 32'd1);
      e.ratio = 8'd0;
      e.dir   = 1'b0;
    end else begin
      e = sb_q.pop_front();
    end
    sb_pending = 1'b0;
  endtask

  // Wait for the acknowledge, then confirm pins, handshake and the following period(s).
  task automatic expect_apply(input string name, input int max_lat, input int min_low, input int periods);
    bit   found;
    int   cycles, low_run, busy_low, highs, first, dones;
    exp_t e;
    wait_done(3 * PERIOD + 10, found, cycles, low_run, busy_low);
    check({name, " done seen"}, 32'(found), 32'd1);
    if (found) begin
      pop_expected(name, e);
      check({name, " latency ok"}, 32'(cycles <= max_lat), 32'd1);
      if (min_low > 0) check({name, " dead low run ok"}, 32'(low_run >= min_low), 32'd1);
      check({name, " busy held"}, 32'(busy_low), 32'd0);
      check({name, " busy after apply"}, 32'(busy), 32'd0);
      check({name, " dir_out"}, 32'(dir_out), 32'(e.dir));
      measure(periods, highs, first, dones);
      check({name, " high ticks"}, 32'(highs), 32'(int'(e.ratio) * periods));
      check({name, " extra done"}, 32'(dones), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    exp_t e;
    int   highs, first, dones;

    checks = 0;
    errors = 0;
    sb_pending = 1'b0;

    vecs[0] = '{ratio: 8'd128, dir: 1'b0, periods: 1, max_lat: PERIOD + 1,     min_low: 0};
    vecs[1] = '{ratio: 8'd0,   dir: 1'b0, periods: 2, max_lat: PERIOD + 1,     min_low: 0};
    vecs[2] = '{ratio: 8'd255, dir: 1'b0, periods: 2, max_lat: PERIOD + 1,     min_low: 0};
    vecs[3] = '{ratio: 8'd100, dir: 1'b0, periods: 1, max_lat: PERIOD + 1,     min_low: 0};
    vecs[4] = '{ratio: 8'd100, dir: 1'b1, periods: 1, max_lat: 3 * PERIOD + 1, min_low: 2 * PERIOD};

    pwm_enable = 1'b1;
    repeat (3) @(negedge clock);
    check("reset pwm_done", 32'(pwm_done), 32'd0);
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset dir_out", 32'(dir_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("idle no done", 32'(pwm_done), 32'd0);

    // Basic duty, 0%/100% across the wrap, and a reversal through dead-time.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].ratio, vecs[i].dir);
      expect_apply($sformatf("vec%0d", i), vecs[i].max_lat, vecs[i].min_low, vecs[i].periods);
    end

    // Three strobes inside one period collapse to one apply of the last.
    send(8'd10, 1'b1);
    send(8'd50, 1'b1);
    send(8'd200, 1'b1);
    check("burst busy", 32'(busy), 32'd1);
    expect_apply("burst", PERIOD + 1, 0, 1);
    measure(1, highs, first, dones);
    check("burst no second done", 32'(dones), 32'd0);
    check("burst steady duty", 32'(highs), 32'd200);

    // Disable with a request pending applies it at once; re-enable restarts at tick 0.
    send(8'd60, 1'b1);
    pwm_enable = 1'b0;
    @(negedge clock);
    check("disable done", 32'(pwm_done), 32'd1);
    check("disable pwm_out", 32'(pwm_out), 32'd0);
    check("disable busy", 32'(busy), 32'd0);
    pop_expected("disable", e);
    check("disable dir_out", 32'(dir_out), 32'(e.dir));
    @(negedge clock);
    check("disable done single", 32'(pwm_done), 32'd0);
    repeat (5) @(negedge clock);
    check("disabled pwm_out", 32'(pwm_out), 32'd0);
    pwm_enable = 1'b1;
    measure(1, highs, first, dones);
    check("reenable first tick high", 32'(first), 32'd1);
    check("reenable high ticks", 32'(highs), 32'(e.ratio));
    check("reenable no done", 32'(dones), 32'd0);

    // Reset while dead-time is running discards the pending request.
    send(8'd150, 1'b0);
    repeat (300) @(negedge clock);
    check("dead busy", 32'(busy), 32'd1);
    check("dead pwm_out", 32'(pwm_out), 32'd0);
    check("dead dir_out held", 32'(dir_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset dir_out", 32'(dir_out), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset pwm_out", 32'(pwm_out), 32'd0);
    check("async reset pwm_done", 32'(pwm_done), 32'd0);
    sb_q.delete();
    sb_pending = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    measure(3, highs, first, dones);
    check("post reset no done", 32'(dones), 32'd0);
    check("post reset no pwm", 32'(highs), 32'd0);
    check("post reset busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
